// File: rtl/uart_tx_periph.sv
// uart_tx_periph: memory-mapped 8N1 UART transmitter with a small transmit FIFO.
// Register window (16 bytes at BASE): 0 TXDATA (write-only push), 1 STATUS,
// 2 DIV (clocks per bit), 3 reserved.
module uart_tx_periph #(
  parameter logic [31:0] BASE        = 32'h2000_0010,
  parameter int unsigned DEFAULT_DIV = 16,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wr,
  input  logic [3:0]  data_wr_en,
  output logic [31:0] data_rd,
  output logic        tx,
  output logic        irq
);

  localparam int unsigned      PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned      CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [15:0]      DIV_RST  = 16'(DEFAULT_DIV);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t           state_q, state_d;
  logic             tx_q, tx_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [15:0]      clk_cnt_q, clk_cnt_d;
  logic [15:0]      div_eff_q, div_eff_d;
  logic [15:0]      div_q, div_d;
  logic             ovf_q, ovf_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       mem_q [FIFO_DEPTH];

  logic       sel;
  logic [1:0] offset;
  logic       wr_txdata, wr_status, wr_div;
  logic       full, pop, push, busy, bit_done;
  logic [2:0] cnt3;
  logic       unused_bits;

  assign sel       = (data_addr[31:4] == BASE[31:4]);
  assign offset    = data_addr[3:2];
  assign wr_txdata = sel && (offset == 2'd0) && data_wr_en[0];
  assign wr_status = sel && (offset == 2'd1) && data_wr_en[0];
  assign wr_div    = sel && (offset == 2'd2) && (data_wr_en[1:0] == 2'b11);

  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  assign full     = (count_q == CNT_FULL);
  assign pop      = (state_q == S_IDLE) && (count_q != '0);
  assign push     = wr_txdata && (!full || pop);
  assign busy     = (state_q != S_IDLE);
  assign bit_done = (clk_cnt_q == div_eff_q - 16'd1);
  assign cnt3     = 3'(count_q);

  assign tx  = tx_q;
  assign irq = (count_q == '0) && (state_q == S_IDLE);

  assign unused_bits = ^{data_addr[1:0], data_wr_en[3:2], data_wr[31:16]};

  // FIFO pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  // Divisor register and sticky overflow flag
  always_comb begin
    div_d = div_q;
    ovf_d = ovf_q;
    if (wr_div) div_d = data_wr[15:0];
    if (wr_status && data_wr[5]) ovf_d = 1'b0;
    if (wr_txdata && full && !pop) ovf_d = 1'b1;
  end

  // Transmit FSM: next state, bit timing and the next serial level
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    clk_cnt_d = clk_cnt_q;
    div_eff_d = div_eff_q;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (pop) begin
          // The divisor is frozen here so DIV writes only affect later frames.
          shift_d   = mem_q[rd_ptr_q];
          div_eff_d = (div_q == '0) ? 16'd1 : div_q;
          clk_cnt_d = '0;
          bit_idx_d = '0;
          tx_d      = 1'b0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          state_d   = S_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Register read mux; unselected and reserved locations read as zero
  always_comb begin
    data_rd = '0;
    if (sel) begin
      case (offset)
        2'd1:    data_rd = {26'b0, ovf_q, busy, cnt3, full};
        2'd2:    data_rd = {16'b0, div_q};
        default: data_rd = '0;
      endcase
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      tx_q      <= 1'b1;
      shift_q   <= '0;
      bit_idx_q <= '0;
      clk_cnt_q <= '0;
      div_eff_q <= 16'd1;
      div_q     <= DIV_RST;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      clk_cnt_q <= clk_cnt_d;
      div_eff_q <= div_eff_d;
      div_q     <= div_d;
      ovf_q     <= ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (rst_n && push) mem_q[wr_ptr_q] <= data_wr[7:0];
  end

endmodule
